// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin front end for a shared combinational ALU.
// One operation in flight; opcode-dependent hold time; registered response.
module alu_arbiter #(
  parameter int unsigned FAST_CYCLES = 1,
  parameter int unsigned SLOW_CYCLES = 4,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_opcode,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_opcode,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [15:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        busy,
  output logic        alu_enable,
  output logic [4:0]  alu_opcode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  input  logic [3:0]  alu_flags
);

  localparam int unsigned OP_W   = 5;
  localparam int unsigned DATA_W = 16;

  // Opcode encodings shared with alu_ops.v
  localparam logic [OP_W-1:0] ALU_MUL = 5'h03;
  localparam logic [OP_W-1:0] ALU_DIV = 5'h04;
  localparam logic [OP_W-1:0] ALU_MOD = 5'h05;
  localparam logic [OP_W-1:0] ALU_CMP = 5'h09;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [OP_W-1:0]   lat_op;
  logic [DATA_W-1:0] lat_a;
  logic [DATA_W-1:0] lat_b;
  logic              owner;
  logic              last_grant;

  logic              grant0;
  logic              grant1;
  logic              accept;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic              sel_slow;

  // Round-robin grant: on contention the port that did not win last time goes
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant;
      grant1 = !last_grant;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = (state == IDLE) && grant0;
  assign req1_ready = (state == IDLE) && grant1;
  assign accept     = req0_ready || req1_ready;

  assign sel_op   = grant1 ? req1_opcode : req0_opcode;
  assign sel_a    = grant1 ? req1_a      : req0_a;
  assign sel_b    = grant1 ? req1_b      : req0_b;
  assign sel_slow = (sel_op == ALU_MUL) || (sel_op == ALU_DIV) || (sel_op == ALU_MOD);

  // ALU operands come straight from the latches so they stay stable through EXEC
  assign alu_opcode = lat_op;
  assign alu_a      = lat_a;
  assign alu_b      = lat_b;

  // Sequencer: accept, hold the ALU for the opcode's cycle count, capture, respond
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_op     <= '0;
      lat_a      <= '0;
      lat_b      <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      busy       <= 1'b0;
      alu_enable <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_op     <= sel_op;
            lat_a      <= sel_a;
            lat_b      <= sel_b;
            owner      <= grant1;
            last_grant <= grant1;
            cnt        <= sel_slow ? CNT_W'(SLOW_CYCLES - 1) : CNT_W'(FAST_CYCLES - 1);
            alu_enable <= 1'b1;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_flags <= alu_flags;
            // CMP only reports flags; the previous result is kept
            if (lat_op != ALU_CMP) begin
              rsp_result <= alu_result;
            end
            rsp0_valid <= !owner;
            rsp1_valid <= owner;
            alu_enable <= 1'b0;
            state      <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. the core pipeline (port 0) and the calculator macro/keypad sequencer (port 1).
- Each request is accepted with a valid/ready handshake, and its operands are latched.
- The block drives the ALU for a fixed, opcode-dependent number of cycles, then registers Result and flags. It returns them with a one-cycle response pulse to the winning port.
- Round-robin arbitration; one operation in flight at a time.

Parameters:
- FAST_CYCLES, 1: ALU hold cycles for all opcodes except MUL/DIV/MOD (minimum 1).
- SLOW_CYCLES, 4: ALU hold cycles for `ALU_MUL, `ALU_DIV and `ALU_MOD (minimum 1).
- CNT_W, 4: width of the hold counter; must hold max(FAST_CYCLES, SLOW_CYCLES).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_opcode  in  5  port 0 ALU opcode (encodings from alu_ops.v).
- req0_a  in  16  port 0 operand A.
- req0_b  in  16  port 0 operand B.
- req1_valid, req1_ready, req1_opcode, req1_a, req1_b: same as port 0, for port 1.
- rsp0_valid  out  1  one-cycle pulse; rsp_result/rsp_flags belong to port 0.
- rsp1_valid  out  1  one-cycle pulse; rsp_result/rsp_flags belong to port 1.
- rsp_result  out  16  registered ALU result.
- rsp_flags  out  4  registered flags {Z,N,C,O}, bit 3 = Z, bit 0 = O.
- busy  out  1  high in EXEC or DONE.
- alu_enable  out  1  ALU enable.
- alu_opcode  out  5  to ALU opcode.
- alu_a  out  16  to ALU A.
- alu_b  out  16  to ALU B.
- alu_result  in  16  from ALU Result.
- alu_flags  in  4  from ALU flags.

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0, latched operands/opcode 0, owner 0. last_grant = 1, so port 0 wins the first contention.
- Reset wins over every other event. Reset mid-EXEC or DONE aborts the operation: no rsp pulse is issued and rsp_result/rsp_flags return to 0.
- State machine, IDLE -> EXEC -> DONE -> IDLE.
- IDLE:
  - Only one requester valid: it is granted.
  - Both valid: grant the port != last_grant.
  - reqN_ready is combinational, = IDLE & grant to N; at most one ready per cycle. No ready is driven outside IDLE.
  - On accept (valid & ready): latch opcode/a/b and owner, set last_grant = owner.
  - Load counter with SLOW_CYCLES-1 for MUL/DIV/MOD, else FAST_CYCLES-1. Go to EXEC.
- EXEC:
  - alu_enable = 1; alu_opcode/alu_a/alu_b driven from the latches and stable for the whole state.
  - Counter decrements each cycle.
  - On the cycle the counter = 0: sample alu_flags into rsp_flags and go to DONE.
  - On that same cycle, sample alu_result into rsp_result unless opcode = `ALU_CMP; for CMP, rsp_result holds its previous value.
- Outside EXEC: alu_enable = 0; alu_opcode/a/b are still driven from the latches.
- DONE: rsp<owner>_valid = 1 for exactly this cycle; return to IDLE.
- rsp_result/rsp_flags hold their value until the next capture.
- Latency:
  - Accept at cycle T; response pulse at T+1+hold.
  - Fast op (hold 1): pulse at T+2. Slow op (hold 4): pulse at T+5.
  - Earliest next accept is the cycle after the pulse (T+3 for a fast op).
- Requests held valid while not ready are not lost. A requester may change its inputs only after accept.
- Unknown or `ALU_NOP/`ALU_TST opcodes take FAST_CYCLES and return whatever the ALU produces. No error signalling.
- No back-pressure on responses: the requester must sample on the pulse.

Test Plan:
- Reset then port 0 ADD, A=0x0003, B=0x0004 -> req0_ready high on the accept cycle; rsp0_valid exactly 2 cycles later; rsp_result=0x0007, rsp_flags=0x0.
- Port 1 DIV, A=100, B=7 -> alu_enable high for 4 consecutive cycles with constant inputs; rsp1_valid 5 cycles after accept; rsp_result=14.
- Both ports valid continuously with SUB 5-5 -> grants alternate 0,1,0,1; each response has rsp_flags Z=1 (0x8); never two readies in one cycle.
- ADD 1+1 (result 2), then CMP A=0x0002, B=0x0005 -> rsp_result stays 0x0002; rsp_flags N=1.
- Assert rst during EXEC of a MUL -> no rsp pulse; outputs 0 the next cycle; a subsequent port 1 request is served normally.
- Hold req0_valid high across a busy period -> it is accepted on the first IDLE cycle after DONE; port 0 sees no duplicated response.
